stack_sequencer: RTL and testbench
==================================

// Module: stack_sequencer
// PURPOSE
//  Consumer of the decoder's push/pop stack bitmasks (STACK_* bit assignments in pre_decode_t).
//  Walks a 16-bit push mask, then a pop mask, issuing one 16-bit stack bus cycle per set bit.
//  Tracks SP through the sequence and writes back the final SP.
//  Sits between the execute unit (register file access) and the bus interface unit (SS-relative accesses).
// PARAMETERS
//  none (widths fixed: 16-bit SP/data, 16-bit mask; bit order per STACK_* constants)
// PORTS
//  clk           in   1   core clock
//  reset_n       in   1   synchronous reset, active low
//  start         in   1   begin sequence; sampled only in IDLE
//  push_mask     in   16  STACK_* bits to push, captured at start
//  pop_mask      in   16  STACK_* bits to pop, captured at start
//  sp_in         in   16  SP value at start
//  busy          out  1   sequence in progress (start ignored)
//  done          out  1   1-cycle pulse, sequence complete
//  sp_we         out  1   1-cycle pulse with done; sp_out valid
//  sp_out        out  16  final SP
//  src_sel       out  4   bit index of item being pushed (regfile read select)
//  src_data      in   16  value for src_sel, combinational from regfile
//  bus_req       out  1   stack bus cycle request, held until bus_ack
//  bus_write     out  1   1 = push (write), 0 = pop (read)
//  bus_addr      out  16  SS-relative offset of access
//  bus_wdata     out  16  write data (push)
//  bus_ack       in   1   access complete; bus_rdata valid this cycle for reads
//  bus_rdata     in   16  read data (pop)
//  dst_we        out  1   1-cycle pulse: write dst_data to item dst_sel
//  dst_sel       out  4   bit index of popped item
//  dst_data      out  16  popped value
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal masks/SP cleared. Reset mid-sequence aborts, no SP write.
//  States: IDLE -> PUSH -> POP -> FINISH -> IDLE; empty phases skipped.
//  IDLE: on start, capture masks and sp_in (sp_cur), set busy next cycle.
//   Go to PUSH if push_mask!=0, else POP if pop_mask!=0, else FINISH.
//  PUSH: item = lowest set bit of remaining push mask (AW first ... PC, OPERAND last).
//   bus_req=1, bus_write=1, bus_addr=sp_cur-2, src_sel=item.
//   bus_wdata = sp_orig if item==4 (STACK_SP pushes SP value at start), else src_data.
//   On bus_ack: sp_cur-=2, clear bit. Next item's bus_req in the following cycle.
//   Mask empty -> POP or FINISH.
//  POP: item = highest set bit of remaining pop mask (reverse of push order).
//   bus_req=1, bus_write=0, bus_addr=sp_cur.
//   On bus_ack: sp_cur+=2; clear bit.
//   If item==5 (SP_DISCARD): no dst_we.
//   If item==4 (STACK_SP): latch rdata as final SP; no dst_we.
//   Else: dst_we=1 next cycle with dst_sel=item, dst_data=bus_rdata (registered).
//  FINISH: done=1, sp_we=1, sp_out = latched popped SP if bit 4 was popped, else sp_cur. Next state IDLE.
//  bus_req drops the cycle after ack; address/data stable while bus_req=1 and ack=0.
//  Latency: start -> bus_req next cycle; last ack -> done next cycle (+1 if final pop needs dst_we).
//  Both masks zero: done/sp_we 2 cycles after start, sp_out=sp_in.
//  SP arithmetic is modulo 2^16: 0x0000-2=0xFFFE, 0xFFFE+2=0x0000.
//  Reserved bit 15 (OPERAND) is handled like any other register item (src/dst via sel=15).
//  start while busy: ignored. bus_ack while bus_req=0: ignored.
// TESTING
//  - push=0x0C00 (PSW,PS), sp_in=0x0100, ack after 3 cycles each
//      -> writes @0x00FE sel10, @0x00FC sel11; sp_out=0x00FC.
//  - push=0x01DF (PUSH ALL), sp_in=0x0010
//      -> 8 writes AW..IY at 0x000E..0x0000; SP item data=0x0010; final 0x0000.
//  - pop=0x01EF (POP ALL incl. SP_DISCARD), sp_in=0x0000
//      -> reads IY..AW at 0x0000..0x000E; no dst_we for bit5; sp_out=0x0010.
//  - pop=0x0010, sp_in=0xFFFE, rdata=0x1234
//      -> read @0xFFFE; no dst_we; sp_out=0x1234.
//  - push=0, pop=0, start
//      -> no bus_req; done+sp_we 2 cycles later; sp_out=sp_in.
//  - reset_n low while bus_req held mid-PUSH
//      -> next cycle all outputs 0, IDLE; no done/sp_we; new start works.

Source files
------------

// File: rtl/stack_sequencer.sv
// Walks a push bitmask then a pop bitmask, issuing one 16-bit stack bus cycle per set bit
// and writing back the final SP once the sequence completes.
module stack_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] push_mask,
  input  logic [15:0] pop_mask,
  input  logic [15:0] sp_in,
  output logic        busy,
  output logic        done,
  output logic        sp_we,
  output logic [15:0] sp_out,
  output logic [3:0]  src_sel,
  input  logic [15:0] src_data,
  output logic        bus_req,
  output logic        bus_write,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        dst_we,
  output logic [3:0]  dst_sel,
  output logic [15:0] dst_data
);

  // state  | meaning
  // IDLE   | waiting for start
  // PUSH   | writing lowest remaining push item
  // POP    | reading highest remaining pop item; empty mask = settle cycle
  // FINISH | done/sp_we pulse with final SP
  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_FINISH} state_t;

  localparam logic [3:0] ITEM_SP      = 4'd4;
  localparam logic [3:0] ITEM_DISCARD = 4'd5;

  state_t      state, state_nxt;
  logic [15:0] push_m, push_m_nxt, pop_m, pop_m_nxt;
  logic [15:0] sp_cur, sp_cur_nxt, sp_orig, sp_orig_nxt, sp_pop, sp_pop_nxt;
  logic        sp_pop_vld, sp_pop_vld_nxt;
  logic        dst_we_nxt;
  logic [3:0]  dst_sel_nxt;
  logic [15:0] dst_data_nxt;
  logic [3:0]  push_item, pop_item;
  logic [15:0] push_m_clr, pop_m_clr;

  always_comb begin
    push_item = '0;
    for (int i = 15; i >= 0; i--)
      if (push_m[i]) push_item = 4'(i);
  end

  always_comb begin
    pop_item = '0;
    for (int i = 0; i < 16; i++)
      if (pop_m[i]) pop_item = 4'(i);
  end

  always_comb begin
    push_m_clr = push_m;
    push_m_clr[push_item] = 1'b0;
    pop_m_clr = pop_m;
    pop_m_clr[pop_item] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      push_m     <= '0;
      pop_m      <= '0;
      sp_cur     <= '0;
      sp_orig    <= '0;
      sp_pop     <= '0;
      sp_pop_vld <= 1'b0;
      dst_we     <= 1'b0;
      dst_sel    <= '0;
      dst_data   <= '0;
    end else begin
      state      <= state_nxt;
      push_m     <= push_m_nxt;
      pop_m      <= pop_m_nxt;
      sp_cur     <= sp_cur_nxt;
      sp_orig    <= sp_orig_nxt;
      sp_pop     <= sp_pop_nxt;
      sp_pop_vld <= sp_pop_vld_nxt;
      dst_we     <= dst_we_nxt;
      dst_sel    <= dst_sel_nxt;
      dst_data   <= dst_data_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    push_m_nxt     = push_m;
    pop_m_nxt      = pop_m;
    sp_cur_nxt     = sp_cur;
    sp_orig_nxt    = sp_orig;
    sp_pop_nxt     = sp_pop;
    sp_pop_vld_nxt = sp_pop_vld;
    dst_we_nxt     = 1'b0;
    dst_sel_nxt    = dst_sel;
    dst_data_nxt   = dst_data;
    busy           = 1'b0;
    done           = 1'b0;
    sp_we          = 1'b0;
    sp_out         = '0;
    src_sel        = '0;
    bus_req        = 1'b0;
    bus_write      = 1'b0;
    bus_addr       = '0;
    bus_wdata      = '0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          push_m_nxt     = push_mask;
          pop_m_nxt      = pop_mask;
          sp_cur_nxt     = sp_in;
          sp_orig_nxt    = sp_in;
          sp_pop_vld_nxt = 1'b0;
          // With nothing to push, POP is entered even if its mask is empty so that
          // an empty sequence still reports done two cycles after start.
          state_nxt      = (push_mask != '0) ? S_PUSH : S_POP;
        end
      end
      S_PUSH: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_addr  = sp_cur - 16'd2;
        src_sel   = push_item;
        bus_wdata = (push_item == ITEM_SP) ? sp_orig : src_data;
        if (bus_ack) begin
          sp_cur_nxt = sp_cur - 16'd2;
          push_m_nxt = push_m_clr;
          if (push_m_clr == '0) state_nxt = (pop_m != '0) ? S_POP : S_FINISH;
        end
      end
      S_POP: begin
        busy = 1'b1;
        if (pop_m == '0) begin
          state_nxt = S_FINISH;
        end else begin
          bus_req  = 1'b1;
          bus_addr = sp_cur;
          if (bus_ack) begin
            sp_cur_nxt = sp_cur + 16'd2;
            pop_m_nxt  = pop_m_clr;
            if (pop_item == ITEM_SP) begin
              sp_pop_nxt     = bus_rdata;
              sp_pop_vld_nxt = 1'b1;
            end else if (pop_item != ITEM_DISCARD) begin
              dst_we_nxt   = 1'b1;
              dst_sel_nxt  = pop_item;
              dst_data_nxt = bus_rdata;
            end
            if (pop_m_clr == '0 && !dst_we_nxt) state_nxt = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        sp_we     = 1'b1;
        sp_out    = sp_pop_vld ? sp_pop : sp_cur;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer: a bus/regfile responder plus a queue-based
// reference model of the expected stack traffic, register writes and final SP.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] push_mask = '0, pop_mask = '0, sp_in = '0;
  logic        busy, done, sp_we;
  logic [15:0] sp_out;
  logic [3:0]  src_sel;
  logic [15:0] src_data;
  logic        bus_req, bus_write;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;
  logic        dst_we;
  logic [3:0]  dst_sel;
  logic [15:0] dst_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] regs [16];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  sel;
  } bus_t;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
  } dst_t;

  bus_t exp_bus[$];
  dst_t exp_dst[$];

  stack_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in),
    .busy(busy), .done(done), .sp_we(sp_we), .sp_out(sp_out),
    .src_sel(src_sel), .src_data(src_data),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dst_we(dst_we), .dst_sel(dst_sel), .dst_data(dst_data)
  );

  always #5 clk = ~clk;

  always_comb src_data = regs[src_sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_seq(input logic [15:0] pm, input logic [15:0] ppm, input logic [15:0] sp);
    logic [15:0] sp_m, sp_final;
    bus_t        b;
    dst_t        d;
    int          lowest_pop, first_req, last_ack, wait_cnt, exp_done;
    bit          fin, any_bus;

    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    exp_bus.delete();
    exp_dst.delete();

    // Reference model: push low->high bit at SP-2, pop high->low bit at SP.
    sp_m = sp;
    for (int i = 0; i < 16; i++) begin
      if (pm[i]) begin
        sp_m   = sp_m - 16'd2;
        b.wr   = 1'b1;
        b.addr = sp_m;
        b.data = (i == 4) ? sp : regs[i];
        b.sel  = 4'(i);
        exp_bus.push_back(b);
      end
    end
    sp_final   = 16'hxxxx;
    lowest_pop = -1;
    for (int i = 15; i >= 0; i--) begin
      if (ppm[i]) begin
        b.wr   = 1'b0;
        b.addr = sp_m;
        b.data = 16'($urandom);
        b.sel  = 4'(i);
        exp_bus.push_back(b);
        sp_m = sp_m + 16'd2;
        if (i == 4) sp_final = b.data;
        else if (i != 5) begin
          d.sel  = 4'(i);
          d.data = b.data;
          exp_dst.push_back(d);
        end
        lowest_pop = i;
      end
    end
    if (!ppm[4]) sp_final = sp_m;
    any_bus = (pm != '0) || (ppm != '0);

    @(negedge clk);
    push_mask = pm;
    pop_mask  = ppm;
    sp_in     = sp;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);

    fin       = 0;
    first_req = -1;
    last_ack  = -1;
    wait_cnt  = -1;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      bus_ack = 1'b0;
      // Noise: start while busy must be ignored.
      start     = ($urandom_range(0, 3) == 0);
      push_mask = 16'($urandom);
      pop_mask  = 16'($urandom);
      sp_in     = 16'($urandom);
      if (bus_req) begin
        if (first_req < 0) first_req = cyc;
        if (exp_bus.size() == 0) begin
          check("unexpected_bus_req", 1, 0);
        end else begin
          check("bus_write", bus_write, exp_bus[0].wr);
          check("bus_addr", bus_addr, exp_bus[0].addr);
          if (exp_bus[0].wr) begin
            check("src_sel", src_sel, exp_bus[0].sel);
            check("bus_wdata", bus_wdata, exp_bus[0].data);
          end
          if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
          if (wait_cnt == 0) begin
            bus_ack   = 1'b1;
            bus_rdata = exp_bus[0].data;
            void'(exp_bus.pop_front());
            last_ack  = cyc;
            wait_cnt  = -1;
          end else begin
            wait_cnt--;
          end
        end
      end else if ($urandom_range(0, 4) == 0) begin
        bus_ack   = 1'b1;
        bus_rdata = 16'($urandom);
      end
      if (dst_we) begin
        if (exp_dst.size() == 0) begin
          check("unexpected_dst_we", 1, 0);
        end else begin
          check("dst_sel", dst_sel, exp_dst[0].sel);
          check("dst_data", dst_data, exp_dst[0].data);
          void'(exp_dst.pop_front());
        end
      end
      if (done) begin
        fin = 1;
        if (any_bus)
          exp_done = last_ack + 1 + ((ppm != '0 && lowest_pop != 4 && lowest_pop != 5) ? 1 : 0);
        else
          exp_done = 2;
        check("sp_we", sp_we, 1);
        check("sp_out", sp_out, sp_final);
        check("done_cycle", cyc, exp_done);
        check("first_req_cycle", first_req, any_bus ? 1 : -1);
        check("bus_left", exp_bus.size(), 0);
        check("dst_left", exp_dst.size(), 0);
      end
    end
    start   = 1'b0;
    bus_ack = 1'b0;
    if (!fin) check("timeout_done", 0, 1);
    @(negedge clk);
    check("idle_after_done", {busy, done, bus_req}, 0);
  endtask

  task automatic reset_midpush();
    bit seen;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    @(negedge clk);
    push_mask = 16'h0C00;
    pop_mask  = 16'h0000;
    sp_in     = 16'h0100;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus_req) seen = 1;
      else @(negedge clk);
    end
    check("rst_req_seen", seen, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_outputs_zero",
          {busy, done, sp_we, sp_out, src_sel, bus_req, bus_write, bus_addr, bus_wdata,
           dst_we, dst_sel, dst_data}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_done", {done, sp_we, bus_req}, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, sp_we, sp_out, src_sel, bus_req, bus_write, bus_addr, bus_wdata,
           dst_we, dst_sel, dst_data}, 0);
    reset_n = 1'b1;

    run_seq(16'h0C00, 16'h0000, 16'h0100);
    run_seq(16'h01DF, 16'h0000, 16'h0010);
    run_seq(16'h0000, 16'h01EF, 16'h0000);
    run_seq(16'h0000, 16'h0010, 16'hFFFE);
    run_seq(16'h0000, 16'h0000, 16'h1234);
    run_seq(16'h8001, 16'h8020, 16'h0002);
    reset_midpush();
    run_seq(16'h0C00, 16'h0000, 16'h0100);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] pm, ppm;
      pm  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      ppm = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_seq(pm, ppm, ($urandom_range(0, 3) == 0) ? 16'h0002 : 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
